cpu6_instr_encoder: RTL and testbench

Field-level RV32I instruction encoder: accepts {kind, funct3, alt, rd, rs1, rs2, imm} requests and produces legal 32-bit machine words for the cpu6 decode path. It is the inverse of the cpu6 controller decode. Used by the debug program-buffer generator and by self-test stimulus to inject instructions into the fetch queue. Encoding is registered into a small output FIFO with valid/ready on both sides. Illegal field combinations are flagged, not silently encoded.

---
 rtl/cpu6_instr_encoder_if.sv | 29 ++
 rtl/cpu6_instr_encoder.sv | 162 ++++++++++++++++
 tb/tb_cpu6_instr_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_instr_encoder_if.sv
// Request/response bus of the cpu6 instruction encoder.
// Field request in, encoded word out, valid/ready on both sides.
interface cpu6_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_kind, in_funct3, in_alt,
        output in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_kind, in_funct3, in_alt,
        input  in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/cpu6_instr_encoder.sv
// RV32I field-level encoder with legality check.
// Results (including error entries) are queued in a small FIFO.
module cpu6_instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    cpu6_instr_encoder_if.slave  bus,
    output logic [CNT_W-1:0]     enc_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    logic [31:0] imm;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alt;
    logic        s12;
    logic        s13;
    logic        s21;
    logic        shift;
    logic [31:0] enc_instr;
    logic        enc_err;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           full;
    logic           push;
    logic           pop;

    assign imm   = bus.in_imm;
    assign f3    = bus.in_funct3;
    assign rd    = bus.in_rd;
    assign rs1   = bus.in_rs1;
    assign rs2   = bus.in_rs2;
    assign alt   = bus.in_alt;
    assign s12   = imm[31:11] == {21{imm[11]}};
    assign s13   = imm[31:12] == {20{imm[12]}};
    assign s21   = imm[31:20] == {12{imm[20]}};
    assign shift = (f3 == 3'd1) || (f3 == 3'd5);

    // Encode the request fields and flag illegal combinations
    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (bus.in_kind)
            4'd0, 4'd1: begin
                enc_err   = imm[11:0] != 12'd0;
                enc_instr = {imm[31:12], rd,
                             (bus.in_kind == 4'd0) ? 7'h37 : 7'h17};
            end
            4'd2: begin
                enc_err   = imm[0] || !s21;
                enc_instr = {imm[20], imm[10:1], imm[11],
                             imm[19:12], rd, 7'h6F};
            end
            4'd3: begin
                enc_err   = (f3 != 3'd0) || !s12;
                enc_instr = {imm[11:0], rs1, f3, rd, 7'h67};
            end
            4'd4: begin
                enc_err   = imm[0] || !s13 ||
                            (f3 == 3'd2) || (f3 == 3'd3);
                enc_instr = {imm[12], imm[10:5], rs2, rs1, f3,
                             imm[4:1], imm[11], 7'h63};
            end
            4'd5: begin
                enc_err   = (f3 == 3'd3) || (f3 == 3'd6) ||
                            (f3 == 3'd7) || !s12;
                enc_instr = {imm[11:0], rs1, f3, rd, 7'h03};
            end
            4'd6: begin
                enc_err   = (f3 > 3'd2) || !s12;
                enc_instr = {imm[11:5], rs2, rs1, f3,
                             imm[4:0], 7'h23};
            end
            4'd7: begin
                if (shift) begin
                    enc_err   = (imm[31:5] != 27'd0) ||
                                (alt && (f3 != 3'd5));
                    enc_instr = {1'b0, alt, 5'd0, imm[4:0],
                                 rs1, f3, rd, 7'h13};
                end else begin
                    enc_err   = !s12 || alt;
                    enc_instr = {imm[11:0], rs1, f3, rd, 7'h13};
                end
            end
            4'd8: begin
                enc_err   = alt && (f3 != 3'd0) && (f3 != 3'd5);
                enc_instr = {1'b0, alt, 5'd0, rs2, rs1, f3,
                             rd, 7'h33};
            end
            4'd9: begin
                enc_err   = (f3 > 3'd1) || !s12;
                enc_instr = {imm[11:0], rs1, f3, rd, 7'h0F};
            end
            4'd10: begin
                enc_err   = (f3 == 3'd0) || (f3 == 3'd4) ||
                            (imm[31:12] != 20'd0);
                enc_instr = {imm[11:0], rs1, f3, rd, 7'h73};
            end
            4'd11: begin
                enc_instr = 32'h3020_0073;
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        if (enc_err) enc_instr = '0;
    end

    assign full          = cnt == FULL_CNT;
    assign bus.in_ready  = ~full;
    assign bus.out_valid = cnt != '0;
    assign push          = bus.in_valid & ~full;
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_instr = bus.out_valid ? mem[rd_ptr].instr : '0;
    assign bus.out_err   = bus.out_valid ? mem[rd_ptr].err : 1'b0;

    // FIFO storage; stale slots are never visible past the head gate
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wr_ptr] <= '{instr: enc_instr, err: enc_err};
        end
    end

    // FIFO pointers, occupancy and legal-encode counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            enc_count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            if (push && !enc_err) begin
                enc_count <= enc_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cpu6_instr_encoder.sv
// Scoreboard bench for cpu6_instr_encoder.
// Reference model encodes from the RV32I field rules.
module tb_cpu6_instr_encoder;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] w;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] enc_count;

    cpu6_instr_encoder_if bus ();

    cpu6_instr_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    exp_t        seen[$];
    logic [15:0] exp_cnt = '0;
    bit          mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int unsigned k, f3, alt,
                                   rd, rs1, rs2, u);
        exp_t        r;
        int          si;
        int unsigned w;
        bit          e;
        bit          s12;
        si  = $signed(u);
        s12 = (si >= -2048) && (si <= 2047);
        w = 0;
        e = 0;
        case (k)
            0, 1: begin
                e = (u % 4096) != 0;
                w = (u / 4096) * 4096 + rd * 128 + (k == 0 ? 'h37 : 'h17);
            end
            2: begin
                e = (u % 2 != 0) || si < -(1 << 20) || si >= (1 << 20);
                w = ((u >> 20) & 1) * (1 << 31) + ((u >> 1) & 1023) * (1 << 21)
                  + ((u >> 11) & 1) * (1 << 20) + ((u >> 12) & 255) * 4096
                  + rd * 128 + 'h6F;
            end
            3: begin
                e = f3 != 0 || !s12;
                w = (u & 4095) * (1 << 20) + rs1 * (1 << 15) + f3 * 4096
                  + rd * 128 + 'h67;
            end
            4: begin
                e = (u % 2 != 0) || si < -4096 || si >= 4096 || f3 == 2 || f3 == 3;
                w = ((u >> 12) & 1) * (1 << 31) + ((u >> 5) & 63) * (1 << 25)
                  + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * 4096
                  + ((u >> 1) & 15) * 256 + ((u >> 11) & 1) * 128 + 'h63;
            end
            5: begin
                e = !(f3 inside {0, 1, 2, 4, 5}) || !s12;
                w = (u & 4095) * (1 << 20) + rs1 * (1 << 15) + f3 * 4096
                  + rd * 128 + 'h03;
            end
            6: begin
                e = f3 > 2 || !s12;
                w = ((u >> 5) & 127) * (1 << 25) + rs2 * (1 << 20)
                  + rs1 * (1 << 15) + f3 * 4096 + (u & 31) * 128 + 'h23;
            end
            7: begin
                if (f3 == 1 || f3 == 5) begin
                    e = u >= 32 || (alt != 0 && f3 != 5);
                    w = alt * (1 << 30) + u * (1 << 20);
                end else begin
                    e = !s12 || alt != 0;
                    w = (u & 4095) * (1 << 20);
                end
                w = w + rs1 * (1 << 15) + f3 * 4096 + rd * 128 + 'h13;
            end
            8: begin
                e = alt != 0 && f3 != 0 && f3 != 5;
                w = alt * (1 << 30) + rs2 * (1 << 20) + rs1 * (1 << 15)
                  + f3 * 4096 + rd * 128 + 'h33;
            end
            9: begin
                e = f3 > 1 || !s12;
                w = (u & 4095) * (1 << 20) + rs1 * (1 << 15) + f3 * 4096
                  + rd * 128 + 'h0F;
            end
            10: begin
                e = f3 == 0 || f3 == 4 || u >= 4096;
                w = u * (1 << 20) + rs1 * (1 << 15) + f3 * 4096
                  + rd * 128 + 'h73;
            end
            11: w = 'h3020_0073;
            default: e = 1;
        endcase
        r.w = e ? 32'd0 : w;
        r.e = e;
        return r;
    endfunction

    // Reference FIFO: pop, then push, on every clock edge
    always @(posedge clk) begin
        bit full_now;
        if (reset) begin
            q.delete();
            exp_cnt = '0;
            mon_en  = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            full_now = q.size() >= DEPTH;
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && !full_now) begin
                exp_t x;
                x = model(bus.in_kind, bus.in_funct3, bus.in_alt, bus.in_rd,
                          bus.in_rs1, bus.in_rs2, bus.in_imm);
                q.push_back(x);
                if (!x.e) exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    // Monitor: compare DUT outputs to the reference head
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
            chk("enc_count", 32'(enc_count), 32'(exp_cnt));
            if (bus.out_valid && q.size() != 0) begin
                chk("out_instr", bus.out_instr, q[0].w);
                chk("out_err", 32'(bus.out_err), 32'(q[0].e));
                if (bus.out_ready) seen.push_back('{bus.out_instr, bus.out_err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, f3, alt, rd, rs1, rs2,
                         input logic [31:0] imm);
        bus.in_kind   = 4'(k);
        bus.in_funct3 = 3'(f3);
        bus.in_alt    = 1'(alt);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_imm    = imm;
    endtask

    // Hold a request until accepted; caller is just past a rising edge
    task automatic send(input int k, f3, alt, rd, rs1, rs2,
                        input logic [31:0] imm);
        bit ok = 1'b0;
        drive(k, f3, alt, rd, rs1, rs2, imm);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: request kind %0d not accepted", k);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d entries left", q.size());
        end
    endtask

    function automatic logic [31:0] rnd_imm();
        int b [12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                       1048574, 1048576, -1048576, -1048578};
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 80)) - 32'd40;
            1: return 32'(b[$urandom_range(0, 11)]);
            2: return $urandom;
            3: return $urandom & 32'hFFFF_F000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom & 32'h0000_0FFF;
        endcase
    endfunction

    logic [31:0] d_w [9] = '{32'h0050_0093, 32'h4020_81B3, 32'h0020_8463,
                             32'h0010_00EF, 32'h3003_12F3, 32'h3020_0073,
                             32'h0, 32'h0, 32'h0};
    logic        d_e [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        step();

        // Directed encodings
        bus.out_ready = 1'b1;
        seen.delete();
        send(7, 0, 0, 1, 0, 0, 32'd5);
        @(negedge clk);
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_instr", bus.out_instr, 32'h0050_0093);
        chk("addi_count", 32'(enc_count), 32'd1);
        step();
        send(8, 0, 1, 3, 1, 2, 32'd0);
        send(4, 0, 0, 0, 1, 2, 32'd8);
        send(2, 0, 0, 1, 0, 0, 32'd2048);
        send(10, 1, 0, 5, 6, 0, 32'h300);
        send(11, 0, 0, 0, 0, 0, 32'd0);
        send(7, 1, 0, 1, 1, 0, 32'd32);
        send(4, 0, 0, 0, 1, 2, 32'd3);
        send(0, 0, 0, 1, 0, 0, 32'h0000_1001);
        drain();
        chk("dir_seen_n", 32'(seen.size()), 32'd9);
        for (int i = 0; i < 9 && i < seen.size(); i++) begin
            chk($sformatf("dir_instr%0d", i), seen[i].w, d_w[i]);
            chk($sformatf("dir_err%0d", i), 32'(seen[i].e), 32'(d_e[i]));
        end
        chk("dir_count", 32'(enc_count), 32'd6);

        // Backpressure: third request held while FIFO full
        seen.delete();
        bus.out_ready = 1'b0;
        fork
            begin
                send(7, 0, 0, 1, 0, 0, 32'd1);
                send(7, 0, 0, 1, 0, 0, 32'd2);
                send(7, 0, 0, 1, 0, 0, 32'd3);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_held_valid", 32'(bus.in_valid), 32'd1);
                chk("bp_held_imm", bus.in_imm, 32'd3);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_seen_n", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk($sformatf("bp_order%0d", i), seen[i].w,
                32'h0000_0093 + 32'((i + 1) << 20));

        // Flush with a simultaneous push
        bus.out_ready = 1'b0;
        send(7, 0, 0, 1, 0, 0, 32'd7);
        send(7, 0, 0, 1, 0, 0, 32'd8);
        drive(7, 0, 0, 1, 0, 0, 32'd9);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_count", 32'(enc_count), 32'd11);
        step();

        // Reset with entries queued and a request presented
        send(7, 0, 0, 1, 0, 0, 32'd10);
        send(8, 0, 0, 1, 2, 3, 32'd0);
        bus.in_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst2_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_instr", bus.out_instr, 32'd0);
        chk("rst2_err", 32'(bus.out_err), 32'd0);
        chk("rst2_ready", 32'(bus.in_ready), 32'd1);
        chk("rst2_count", 32'(enc_count), 32'd0);
        step();

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), rnd_imm());
            bus.in_valid  = $urandom_range(0, 9) < 6;
            bus.out_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 49) == 0;
            reset = $urandom_range(0, 99) == 0;
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        drain();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
